// File: rtl/led_sequencer.sv
// LED pattern sequencer: each accepted tick steps a rotate, ping-pong or flash pattern.
// A tick that arrives with a new mode reloads that mode's seed instead of stepping.
module led_sequencer #(
    parameter int N_LEDS = 4,
    parameter int N_MODE = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [N_MODE-1:0] i_mode,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_wrap,
    output logic [N_MODE-1:0] o_mode
);

    localparam logic [N_MODE-1:0] MODE_ROT_L = N_MODE'(0);
    localparam logic [N_MODE-1:0] MODE_ROT_R = N_MODE'(1);
    localparam logic [N_MODE-1:0] MODE_PP    = N_MODE'(2);
    localparam logic [N_MODE-1:0] MODE_FLASH = N_MODE'(3);
    localparam logic [N_LEDS-1:0] SEED       = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] ALL_ON     = '1;

    typedef enum logic [2:0] {
        ST_ROT_L,
        ST_ROT_R,
        ST_PP_UP,
        ST_PP_DN,
        ST_FLASH_ON,
        ST_FLASH_OFF
    } state_t;

    state_t            state;
    state_t            step_state;
    state_t            reload_state;
    logic [N_LEDS-1:0] step_led;
    logic [N_LEDS-1:0] reload_led;
    logic              step_wrap;

    always_comb begin
        step_led   = o_led;
        step_state = state;
        step_wrap  = 1'b0;
        case (state)
            ST_ROT_L: step_led = {o_led[N_LEDS-2:0], o_led[N_LEDS-1]};
            ST_ROT_R: step_led = {o_led[0], o_led[N_LEDS-1:1]};
            ST_PP_UP: begin
                step_led = o_led << 1;
                if (step_led[N_LEDS-1]) step_state = ST_PP_DN;
            end
            ST_PP_DN: begin
                step_led = o_led >> 1;
                if (step_led[0]) step_state = ST_PP_UP;
            end
            ST_FLASH_ON: begin
                step_led   = '0;
                step_state = ST_FLASH_OFF;
            end
            ST_FLASH_OFF: begin
                step_led   = ALL_ON;
                step_state = ST_FLASH_ON;
            end
            default: begin
                step_led   = SEED;
                step_state = ST_ROT_L;
            end
        endcase
        // A period ends whenever a step lands back on the current mode's seed.
        if (state == ST_FLASH_ON || state == ST_FLASH_OFF)
            step_wrap = (step_led == ALL_ON);
        else
            step_wrap = (step_led == SEED);
    end

    always_comb begin
        reload_led   = SEED;
        reload_state = ST_ROT_L;
        case (i_mode)
            MODE_ROT_L: reload_state = ST_ROT_L;
            MODE_ROT_R: reload_state = ST_ROT_R;
            MODE_PP:    reload_state = ST_PP_UP;
            MODE_FLASH: begin
                reload_led   = ALL_ON;
                reload_state = ST_FLASH_ON;
            end
            default:    reload_state = ST_ROT_L;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_led  <= SEED;
            o_wrap <= 1'b0;
            o_mode <= MODE_ROT_L;
            state  <= ST_ROT_L;
        end else begin
            o_wrap <= 1'b0;
            if (i_valid) begin
                if (i_mode != o_mode) begin
                    o_mode <= i_mode;
                    o_led  <= reload_led;
                    state  <= reload_state;
                end else begin
                    o_led  <= step_led;
                    state  <= step_state;
                    o_wrap <= step_wrap;
                end
            end
        end
    end

endmodule
